tile_load_sched: RTL
====================

TILE_LOAD_SCHED -- requirements
Module: tile_load_sched

Interface
REQ-001 Parameter REG_WIDTH, default 32, width of the pass-count and timeout registers.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit on bus ownership (used only under REQ-029).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; latches num_passes and begins a sequence; ignored unless IDLE.
REQ-006 num_passes  input  REG_WIDTH  number of IA×weight tile passes in the sequence.
REQ-007 ia_load_req / wt_load_req  input  1 each  load-bus requests from the IA loader / weight loader.
REQ-008 ia_load_granted / wt_load_granted  output  1 each  one-cycle grant pulses.
REQ-009 ia_data_valid / wt_data_valid  input  1 each  loader tile buffer full.
REQ-010 ia_sending_done  input  1  IA tile fully streamed into the array.
REQ-011 send_trigger  output  1  one-cycle pulse to both loaders to start streaming.
REQ-012 busy  output  1  high from the cycle after accepted start until done.
REQ-013 done  output  1  one-cycle pulse at sequence end.
REQ-014 pass_count  output  REG_WIDTH  passes completed in the current sequence.
REQ-015 err  output  1  sticky watchdog error; cleared by start.

Function
REQ-016 Main FSM states IDLE, WAIT_DATA, SEND, FINISH; transitions registered.
REQ-017 IDLE + start: num_passes==0 -> FINISH; otherwise -> WAIT_DATA, pass_count<=0.
REQ-018 WAIT_DATA: when ia_data_valid && wt_data_valid, send_trigger=1 for exactly that cycle, -> SEND next cycle.
REQ-019 SEND: on ia_sending_done, pass_count++; if new pass_count==num_passes -> FINISH, else -> WAIT_DATA.
REQ-020 FINISH: done=1 for one cycle, busy=0, -> IDLE; pass_count holds its final value until the next start.
REQ-021 Load-bus arbiter runs in all states except IDLE and FINISH; it has at most one owner (NONE, IA, WT).
REQ-022 Owner NONE with request(s) pending: grant pulse to the winner; owner<=winner the same edge.
REQ-023 Both requesting simultaneously: round-robin; the requester not granted last wins; first contention after reset goes to IA.
REQ-024 Ownership is released on the cycle the owner's data_valid is sampled high; a new grant can issue in the following cycle (grant-to-grant minimum 2 cycles).
REQ-025 Requests while an owner exists are held off, not dropped; no grant ever issues to a non-requesting loader.
REQ-026 Grants are permitted during SEND (prefetch); send_trigger never coincides with a grant-driven state change of the main FSM.

Reset
REQ-027 On rst: FSM IDLE, owner NONE, round-robin pointer to IA, pass_count=0, all outputs 0; effective asynchronously mid-operation, with no further pulses until the next start.

Configuration
REQ-028 Macro SCHED_TIMEOUT_EN selects the ownership watchdog.
REQ-029 With SCHED_TIMEOUT_EN defined, a counter runs while an owner is held; at TIMEOUT_CYCLES it forces owner NONE and sets err=1 (sticky). Without the macro, there is no counter and err is tied 0.

Structure
REQ-030 Package tile_sched_pkg holds the sched_state_t enum (IDLE, WAIT_DATA, SEND, FINISH) and the bus_owner_t enum (NONE, IA, WT).
REQ-031 One sub-module, rr_arb2: a two-requester round-robin arbiter with enable, grant outputs, and last-winner pointer; the owner lock stays in tile_load_sched.

Verification
REQ-032 start, num_passes=3, both loaders request, then assert valid 4 cycles after grant -> IA granted first, WT next; three send_trigger pulses; pass_count=3; done 1 cycle after the third ia_sending_done.
REQ-033 start, num_passes=0 -> done in the cycle after start; no grant and no send_trigger.
REQ-034 IA and WT request every cycle with valid returned immediately -> grants alternate IA, WT, IA, WT, spaced 2 cycles apart.
REQ-035 rst asserted during SEND with pass_count=1 -> all outputs 0 at once; a later ia_sending_done produces no pulse.
REQ-036 With SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, IA granted and valid never asserted -> err=1 after 8 cycles and a pending WT request is granted the next cycle; without the macro, err stays 0 and WT is held.

Source files
------------

// File: rtl/tile_sched_pkg.sv
// Shared types for the tile load scheduler: main sequence states and load-bus owners.
package tile_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2,
        FINISH    = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IA   = 2'd1,
        WT   = 2'd2
    } bus_owner_t;

endpackage

// File: rtl/tile_load_sched_if.sv
// Control/handshake bundle between the scheduler (slave) and its environment (master),
// plus read-only debug taps of the scheduler's internal state.
interface tile_load_sched_if #(
    parameter int REG_WIDTH = 32
);
    import tile_sched_pkg::*;

    // Handshakes: a loader holds *_load_req until it sees the one-cycle *_load_granted pulse,
    // then owns the load bus until its *_data_valid is sampled high (tile buffer full).
    // send_trigger is a one-cycle pulse issued only when both data_valid are high;
    // ia_sending_done is a one-cycle pulse from the IA side when the tile is fully streamed.
    logic                 start;
    logic [REG_WIDTH-1:0] num_passes;
    logic                 ia_load_req;
    logic                 wt_load_req;
    logic                 ia_load_granted;
    logic                 wt_load_granted;
    logic                 ia_data_valid;
    logic                 wt_data_valid;
    logic                 ia_sending_done;
    logic                 send_trigger;
    logic                 busy;
    logic                 done;
    logic [REG_WIDTH-1:0] pass_count;
    logic                 err;

    sched_state_t         state;
    bus_owner_t           owner;
    logic                 rr_last_ia;

    modport master (
        output start, num_passes, ia_load_req, wt_load_req,
               ia_data_valid, wt_data_valid, ia_sending_done,
        input  ia_load_granted, wt_load_granted, send_trigger, busy, done,
               pass_count, err, state, owner, rr_last_ia
    );

    modport slave (
        input  start, num_passes, ia_load_req, wt_load_req,
               ia_data_valid, wt_data_valid, ia_sending_done,
        output ia_load_granted, wt_load_granted, send_trigger, busy, done,
               pass_count, err, state, owner, rr_last_ia
    );

endinterface

// File: rtl/tile_load_sched_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the IA loader, bit 1 the weight loader.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last_ia
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_ia ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Cleared at reset so the first contention goes to IA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ia <= 1'b0;
        end else if (gnt[0]) begin
            last_ia <= 1'b1;
        end else if (gnt[1]) begin
            last_ia <= 1'b0;
        end
    end

endmodule

// File: rtl/tile_load_sched.sv
// Tile load scheduler: sequences IA x weight tile passes and arbitrates the shared load bus.
// Build option SCHED_TIMEOUT_EN adds a bus-ownership watchdog that drives the sticky err flag.
module tile_load_sched
    import tile_sched_pkg::*;
#(
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst,
    tile_load_sched_if.slave bus
);

    sched_state_t         state;
    sched_state_t         state_next;
    bus_owner_t           owner;
    logic [REG_WIDTH-1:0] num_passes_q;
    logic [REG_WIDTH-1:0] pass_count_q;
    logic [REG_WIDTH-1:0] pass_next;
    logic                 start_accept;
    logic                 send_fire;
    logic                 arb_run;
    logic                 owner_release;
    logic                 timeout;
    logic [1:0]           gnt;
    logic                 last_ia;

    assign start_accept = (state == IDLE) && bus.start;
    assign arb_run      = (state == WAIT_DATA) || (state == SEND);
    assign pass_next    = pass_count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        send_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.num_passes == '0) ? FINISH : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.ia_data_valid && bus.wt_data_valid) begin
                    send_fire  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.ia_sending_done) begin
                    state_next = (pass_next == num_passes_q) ? FINISH : WAIT_DATA;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_passes_q <= '0;
            pass_count_q <= '0;
        end else if (start_accept) begin
            num_passes_q <= bus.num_passes;
            pass_count_q <= '0;
        end else if ((state == SEND) && bus.ia_sending_done) begin
            pass_count_q <= pass_next;
        end
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_run && (owner == NONE)),
        .req     ({bus.wt_load_req, bus.ia_load_req}),
        .gnt     (gnt),
        .last_ia (last_ia)
    );

    always_comb begin
        owner_release = 1'b0;
        case (owner)
            IA:      owner_release = bus.ia_data_valid;
            WT:      owner_release = bus.wt_data_valid;
            default: owner_release = 1'b0;
        endcase
    end

    // The lock is frozen outside WAIT_DATA/SEND; a still-full buffer releases it on the next run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= NONE;
        end else if (arb_run) begin
            if (owner == NONE) begin
                if (gnt[0]) begin
                    owner <= IA;
                end else if (gnt[1]) begin
                    owner <= WT;
                end
            end else if (owner_release || timeout) begin
                owner <= NONE;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    logic [REG_WIDTH-1:0] wd_cnt;
    logic                 err_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive held cycle; a release in that cycle wins.
    assign timeout = arb_run && (owner != NONE) && !owner_release &&
                     (wd_cnt == REG_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (start_accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
            if (!arb_run || (owner == NONE) || owner_release || timeout) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign bus.ia_load_granted = gnt[0];
    assign bus.wt_load_granted = gnt[1];
    assign bus.send_trigger    = send_fire;
    assign bus.busy            = arb_run;
    assign bus.done            = (state == FINISH);
    assign bus.pass_count      = pass_count_q;
    assign bus.state           = state;
    assign bus.owner           = owner;
    assign bus.rr_last_ia      = last_ia;

endmodule
